// File: rtl/dequant_zigzag_writer.sv
// dequant_zigzag_writer: dequantizes zig-zag ordered 8x8 coefficients, reorders
// each block to row-major and writes it into the pre-IDCT SRAM region
// (Y blocks, then U, then V).
// Optional feature macro: DEQ_PINGPONG_BUFFER_EN adds a second block buffer so
// filling continues while the previous block drains to SRAM.
`timescale 1ns/1ps
module dequant_zigzag_writer #(
   parameter logic [17:0] BASE_ADDR  = 18'd76800,
   parameter int          Y_WIDTH    = 320,
   parameter int          UV_WIDTH   = 160,
   parameter int          IMG_HEIGHT = 240
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Enable,
   input  logic [15:0] coeff_in,
   input  logic        coeff_valid,
   output logic        coeff_ready,
   input  logic        q_select,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        block_done,
   output logic        frame_done
);

`ifdef DEQ_PINGPONG_BUFFER_EN
   localparam int   AW       = 7;
   localparam logic PINGPONG = 1'b1;
`else
   localparam int   AW       = 6;
   localparam logic PINGPONG = 1'b0;
`endif
   localparam int DEPTH     = 1 << AW;
   localparam int Y_BPR     = Y_WIDTH / 8;
   localparam int UV_BPR    = UV_WIDTH / 8;
   localparam int Y_BLOCKS  = Y_BPR * (IMG_HEIGHT / 8);
   localparam int UV_BLOCKS = UV_BPR * (IMG_HEIGHT / 8);
   localparam logic [11:0] FIRST_UV = 12'(Y_BLOCKS);
   localparam logic [11:0] NUM_BLK  = 12'(Y_BLOCKS + 2 * UV_BLOCKS);
   localparam logic [11:0] LAST_BLK = NUM_BLK - 12'd1;

   // Row-major position (r*8+c) of each zig-zag index
   localparam logic [5:0] ZZ_POS [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

   // log2 of the quantizer step for a diagonal d = r + c
   function automatic logic [2:0] shift_for(input logic qs, input logic [3:0] d);
      logic [2:0] s;
      if (!qs) begin
         case (d)
            4'd0:       s = 3'd3;
            4'd1:       s = 3'd2;
            4'd2, 4'd3: s = 3'd3;
            4'd4, 4'd5: s = 3'd4;
            4'd6, 4'd7: s = 3'd5;
            default:    s = 3'd6;
         endcase
      end else begin
         case (d)
            4'd0:             s = 3'd3;
            4'd1, 4'd2, 4'd3: s = 3'd1;
            4'd4, 4'd5:       s = 3'd2;
            4'd6, 4'd7:       s = 3'd3;
            default:          s = 3'd4;
         endcase
      end
      return s;
   endfunction

   state_t      state_q, state_d;
   logic [5:0]  idx_q, idx_d, wr_cnt_q, wr_cnt_d, bc_q, bc_d;
   logic        q_sel_q, q_sel_d, fill_sel_q, fill_sel_d, drain_sel_q, drain_sel_d;
   logic [1:0]  full_q, full_d;
   logic [11:0] fill_cnt_q, fill_cnt_d, blk_q, blk_d;
   logic [17:0] row_base_q, row_base_d;
   logic        block_done_q, block_done_d, frame_done_q, frame_done_d;
   logic        xfer, buf_we, is_uv;
   logic [AW-1:0] buf_waddr, buf_raddr;
   logic [15:0] buf_wdata;
   logic [15:0] buf_q [DEPTH];
   logic [5:0]  pos;
   logic [3:0]  diag;
   logic [2:0]  shamt;
   logic        q_eff;
   logic [23:0] wide;
   logic [17:0] row_off;

   // Dequantize the incoming coefficient and saturate it to 16-bit signed
   always_comb begin
      pos   = ZZ_POS[idx_q];
      diag  = {1'b0, pos[5:3]} + {1'b0, pos[2:0]};
      q_eff = (idx_q == 6'd0) ? q_select : q_sel_q;
      shamt = shift_for(q_eff, diag);
      wide  = {{8{coeff_in[15]}}, coeff_in} << shamt;
      if ($signed(wide) > 24'sd32767) begin
         buf_wdata = 16'h7FFF;
      end else if ($signed(wide) < -24'sd32768) begin
         buf_wdata = 16'h8000;
      end else begin
         buf_wdata = wide[15:0];
      end
   end

   // Drain-side address pieces: plane, row offset within block, buffer read index
   always_comb begin
      is_uv     = (blk_q >= FIRST_UV);
      row_off   = is_uv ? 18'(wr_cnt_q[5:3]) * 18'(UV_WIDTH)
                        : 18'(wr_cnt_q[5:3]) * 18'(Y_WIDTH);
      buf_raddr = AW'({drain_sel_q, wr_cnt_q});
   end

   assign coeff_ready     = (state_q != S_IDLE) && !full_q[fill_sel_q] && (fill_cnt_q != NUM_BLK);
   assign SRAM_we_n       = (state_q != S_WRITE);
   assign SRAM_address    = SRAM_we_n ? 18'd0
                          : row_base_q + 18'({bc_q, 3'b000}) + row_off + 18'(wr_cnt_q[2:0]);
   assign SRAM_write_data = SRAM_we_n ? 16'd0 : buf_q[buf_raddr];
   assign block_done      = block_done_q;
   assign frame_done      = frame_done_q;

   // Next-state logic: fill side accepts coefficients, drain side writes SRAM
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      wr_cnt_d     = wr_cnt_q;
      bc_d         = bc_q;
      q_sel_d      = q_sel_q;
      fill_sel_d   = fill_sel_q;
      drain_sel_d  = drain_sel_q;
      full_d       = full_q;
      fill_cnt_d   = fill_cnt_q;
      blk_d        = blk_q;
      row_base_d   = row_base_q;
      block_done_d = 1'b0;
      frame_done_d = 1'b0;
      buf_we       = 1'b0;
      buf_waddr    = AW'({fill_sel_q, pos});
      xfer         = coeff_valid && coeff_ready;

      if (state_q == S_IDLE) begin
         if (Enable) begin
            state_d     = S_FILL;
            idx_d       = 6'd0;
            wr_cnt_d    = 6'd0;
            bc_d        = 6'd0;
            fill_sel_d  = 1'b0;
            drain_sel_d = 1'b0;
            full_d      = 2'b00;
            fill_cnt_d  = 12'd0;
            blk_d       = 12'd0;
            row_base_d  = BASE_ADDR;
         end
      end else begin
         if (xfer) begin
            buf_we = 1'b1;
            idx_d  = idx_q + 6'd1;
            if (idx_q == 6'd0) begin
               q_sel_d = q_select;
            end
            if (idx_q == 6'd63) begin
               full_d[fill_sel_q] = 1'b1;
               fill_sel_d         = fill_sel_q ^ PINGPONG;
               fill_cnt_d         = fill_cnt_q + 12'd1;
            end
         end
         case (state_q)
            S_FILL: begin
               if (full_d[drain_sel_q]) begin
                  state_d  = S_WRITE;
                  wr_cnt_d = 6'd0;
               end
            end
            S_WRITE: begin
               wr_cnt_d = wr_cnt_q + 6'd1;
               if (wr_cnt_q == 6'd63) begin
                  block_done_d        = 1'b1;
                  full_d[drain_sel_q] = 1'b0;
                  drain_sel_d         = drain_sel_q ^ PINGPONG;
                  if (blk_q == LAST_BLK) begin
                     frame_done_d = 1'b1;
                     state_d      = S_IDLE;
                  end else begin
                     blk_d = blk_q + 12'd1;
                     // Plane offsets equal whole planes, so stepping one block row past
                     // the last row of a plane lands exactly on the next plane's start
                     if (bc_q == (is_uv ? 6'(UV_BPR - 1) : 6'(Y_BPR - 1))) begin
                        bc_d       = 6'd0;
                        row_base_d = row_base_q + (is_uv ? 18'(8 * UV_WIDTH) : 18'(8 * Y_WIDTH));
                     end else begin
                        bc_d = bc_q + 6'd1;
                     end
                     if (!full_d[drain_sel_d]) begin
                        state_d = S_FILL;
                     end
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and counter registers
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q      <= S_IDLE;
         idx_q        <= 6'd0;
         wr_cnt_q     <= 6'd0;
         bc_q         <= 6'd0;
         q_sel_q      <= 1'b0;
         fill_sel_q   <= 1'b0;
         drain_sel_q  <= 1'b0;
         full_q       <= 2'b00;
         fill_cnt_q   <= 12'd0;
         blk_q        <= 12'd0;
         row_base_q   <= 18'd0;
         block_done_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         wr_cnt_q     <= wr_cnt_d;
         bc_q         <= bc_d;
         q_sel_q      <= q_sel_d;
         fill_sel_q   <= fill_sel_d;
         drain_sel_q  <= drain_sel_d;
         full_q       <= full_d;
         fill_cnt_q   <= fill_cnt_d;
         blk_q        <= blk_d;
         row_base_q   <= row_base_d;
         block_done_q <= block_done_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Block buffer storage, written in row-major positions
   always_ff @(posedge Clock) begin
      if (buf_we) begin
         buf_q[buf_waddr] <= buf_wdata;
      end
   end

endmodule
